// File: rtl/dt_map_stats.sv
// dt_map_stats: single raster pass over the DT result map reporting peak, peak address, object count and distance sum.
// Optional packed threshold mask built when DT_STATS_MASK_EN is defined.
module dt_map_stats #(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 8,
   parameter int N_PIX  = 16384
)(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_start,
   output logic                     o_busy,
   output logic                     o_done,
   output logic                     o_res_rd,
   output logic [ADDR_W-1:0]        o_res_addr,
   input  logic [DATA_W-1:0]        i_res_di,
   input  logic [DATA_W-1:0]        i_threshold,
   output logic [DATA_W-1:0]        o_max_val,
   output logic [ADDR_W-1:0]        o_max_addr,
   output logic [ADDR_W:0]          o_obj_cnt,
   output logic [ADDR_W+DATA_W-1:0] o_dist_sum,
   output logic                     o_msk_wr,
   output logic [ADDR_W-5:0]        o_msk_addr,
   output logic [15:0]              o_msk_do
);
   localparam logic [1:0] S_IDLE = 2'd0, S_SCAN = 2'd1, S_DRAIN = 2'd2, S_DONE = 2'd3;
   logic [1:0]              r_state;
   logic [ADDR_W-1:0]       r_addr, r_paddr, r_max_addr;
   logic                    r_vld;
   logic [DATA_W-1:0]       r_max;
   logic [ADDR_W:0]         r_cnt;
   logic [ADDR_W+DATA_W-1:0] r_sum;
   logic                    w_start, w_last;
   assign w_start = (r_state == S_IDLE) && i_start;
   assign w_last  = r_addr == ADDR_W'(N_PIX - 1);
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         r_state <= S_IDLE;
         r_addr  <= '0;
         r_vld   <= 1'b0;
         r_paddr <= '0;
      end else begin
         r_vld   <= r_state == S_SCAN;
         r_paddr <= r_addr;
         case (r_state)
            S_IDLE:  if (i_start) r_state <= S_SCAN;
            S_SCAN:  begin
               r_addr <= w_last ? '0 : r_addr + 1'b1;
               if (w_last) r_state <= S_DRAIN;
            end
            S_DRAIN: r_state <= S_DONE;
            default: r_state <= S_IDLE;
         endcase
      end
   // r_vld/r_paddr track the address whose data is on i_res_di this cycle
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         r_max      <= '0;
         r_max_addr <= '0;
         r_cnt      <= '0;
         r_sum      <= '0;
      end else if (w_start) begin
         r_max      <= '0;
         r_max_addr <= '0;
         r_cnt      <= '0;
         r_sum      <= '0;
      end else if (r_vld) begin
         r_sum <= r_sum + (ADDR_W+DATA_W)'(i_res_di);
         r_cnt <= r_cnt + (ADDR_W+1)'(i_res_di != '0);
         if (i_res_di > r_max) begin
            r_max      <= i_res_di;
            r_max_addr <= r_paddr;
         end
      end
   assign o_busy     = r_state != S_IDLE;
   assign o_done     = r_state == S_DONE;
   assign o_res_rd   = r_state == S_SCAN;
   assign o_res_addr = r_addr;
   assign o_max_val  = r_max;
   assign o_max_addr = r_max_addr;
   assign o_obj_cnt  = r_cnt;
   assign o_dist_sum = r_sum;
`ifdef DT_STATS_MASK_EN
   logic [DATA_W-1:0] r_thr;
   logic [14:0]       r_sh;
   logic              r_mwr;
   logic [ADDR_W-5:0] r_maddr;
   logic [15:0]       r_mdo;
   logic              w_bit;
   assign w_bit = i_res_di >= r_thr;
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         r_thr   <= '0;
         r_sh    <= '0;
         r_mwr   <= 1'b0;
         r_maddr <= '0;
         r_mdo   <= '0;
      end else begin
         r_mwr <= 1'b0;
         if (w_start) r_thr <= (i_threshold == '0) ? DATA_W'(1) : i_threshold;
         if (r_vld) begin
            r_sh <= {w_bit, r_sh[14:1]};
            if (&r_paddr[3:0]) begin
               r_mwr   <= 1'b1;
               r_mdo   <= {w_bit, r_sh};
               r_maddr <= r_paddr[ADDR_W-1:4];
            end
         end
      end
   assign o_msk_wr   = r_mwr;
   assign o_msk_addr = r_maddr;
   assign o_msk_do   = r_mdo;
`else
   logic w_unused;
   assign w_unused   = ^i_threshold;
   assign o_msk_wr   = 1'b0;
   assign o_msk_addr = '0;
   assign o_msk_do   = '0;
`endif
endmodule

// File: tb/tb_dt_map_stats.sv
// tb_dt_map_stats: directed scans against a RAM model; a scoreboard queue holds expected results popped on done.
module tb_dt_map_stats;
   typedef struct {
      int mv; int ma; int oc; int ds; int m0;
   } exp_t;
   logic        clk = 0, reset = 0, i_start = 0;
   logic        o_busy, o_done, o_res_rd, o_msk_wr;
   logic [13:0] o_res_addr, o_max_addr;
   logic [7:0]  i_res_di = 0, i_threshold = 0, o_max_val;
   logic [14:0] o_obj_cnt;
   logic [21:0] o_dist_sum;
   logic [9:0]  o_msk_addr;
   logic [15:0] o_msk_do;
   logic [7:0]  mem [16384];
   exp_t        sb[$];
   int cyc = 0, t0 = 0, n_chk = 0, n_fail = 0;
   int rd_cnt, addr_err, done_cnt = 0, mw_cnt, mw_err, m0_got;

   dt_map_stats dut (
      .clk(clk), .reset(reset), .i_start(i_start), .o_busy(o_busy), .o_done(o_done),
      .o_res_rd(o_res_rd), .o_res_addr(o_res_addr), .i_res_di(i_res_di), .i_threshold(i_threshold),
      .o_max_val(o_max_val), .o_max_addr(o_max_addr), .o_obj_cnt(o_obj_cnt), .o_dist_sum(o_dist_sum),
      .o_msk_wr(o_msk_wr), .o_msk_addr(o_msk_addr), .o_msk_do(o_msk_do)
   );

   always #5 clk = ~clk;
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (o_res_rd) i_res_di <= mem[o_res_addr];
   end

   task automatic check(input string n, input longint a, input longint e);
      n_chk++;
      if (a != e) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", n, a, e);
      end
   endtask

   // monitor: address stream, mask writes and scoreboard pop on done
   always @(negedge clk) if (reset) begin
      if (o_res_rd) begin
         rd_cnt++;
         if (o_res_addr != 14'(cyc - t0 - 1)) addr_err++;
      end
      if (o_msk_wr) begin
         mw_cnt++;
         if (mw_cnt == 1) m0_got = o_msk_do;
         if ((cyc - t0 - 18) % 16 != 0 || o_msk_addr != 10'((cyc - t0 - 18) / 16)) mw_err++;
      end
      if (o_done) begin
         exp_t e;
         done_cnt++;
         if (sb.size() == 0) check("unexpected_done", 1, 0);
         else begin
            e = sb.pop_front();
            check("max_val", o_max_val, e.mv);
            check("max_addr", o_max_addr, e.ma);
            check("obj_cnt", o_obj_cnt, e.oc);
            check("dist_sum", o_dist_sum, e.ds);
            check("rd_cnt", rd_cnt, 16384);
            check("addr_err", addr_err, 0);
            check("done_cyc", cyc - t0, 16386);
`ifdef DT_STATS_MASK_EN
            check("msk_cnt", mw_cnt, 1024);
            check("msk_err", mw_err, 0);
            check("msk_word0", m0_got, e.m0);
`else
            check("msk_cnt", mw_cnt, 0);
`endif
         end
      end
   end

   task automatic fill(input int v);
      for (int i = 0; i < 16384; i++) mem[i] = 8'(v);
   endtask

   task automatic start_scan(input int mv, input int ma, input int oc, input int ds);
      exp_t e;
      int thr = (i_threshold == 0) ? 1 : int'(i_threshold);
      e.mv = mv; e.ma = ma; e.oc = oc; e.ds = ds; e.m0 = 0;
      for (int i = 0; i < 16; i++) if (int'(mem[i]) >= thr) e.m0 |= 1 << i;
      @(negedge clk);
      rd_cnt = 0; addr_err = 0; mw_cnt = 0; mw_err = 0; m0_got = -1;
      sb.push_back(e);
      i_start = 1; t0 = cyc;
      @(negedge clk);
      i_start = 0;
      check("busy_after_start", o_busy, 1);
   endtask

   task automatic wait_done();
      int d0 = done_cnt;
      int n = 0;
      while (done_cnt == d0 && n < 20000) begin @(negedge clk); n++; end
      if (done_cnt == d0) check("done_timeout", 0, 1);
      @(negedge clk);
      check("busy_after_done", o_busy, 0);
   endtask

   task automatic run(input int mv, input int ma, input int oc, input int ds);
      start_scan(mv, ma, oc, ds);
      wait_done();
   endtask

   initial begin
      int d0, n;
      fill(0);
      repeat (3) @(negedge clk);
      check("rst_busy", o_busy, 0);
      check("rst_res_rd", o_res_rd, 0);
      check("rst_max_val", o_max_val, 0);
      check("rst_dist_sum", o_dist_sum, 0);
      reset = 1;
      @(negedge clk);
      check("idle_done", o_done, 0);
      run(0, 0, 0, 0);
      mem[300] = 5;
      run(5, 300, 1, 5);
      repeat (4) @(negedge clk);
      check("hold_max_addr", o_max_addr, 300);
      fill(0); mem[100] = 9; mem[200] = 9; mem[50] = 3;
      run(9, 100, 3, 21);
      fill(255);
      run(255, 0, 16384, 4177920);
      fill(0); mem[100] = 9; mem[200] = 9; mem[50] = 3;
      start_scan(9, 100, 3, 21);
      n = 0;
      while (o_res_addr != 14'd5000 && n < 6000) begin @(negedge clk); n++; end
      check("reached_5000", o_res_addr, 5000);
      d0 = done_cnt;
      reset = 0;
      #1;
      sb.delete();
      check("midrst_busy", o_busy, 0);
      check("midrst_res_rd", o_res_rd, 0);
      check("midrst_max_val", o_max_val, 0);
      check("midrst_obj_cnt", o_obj_cnt, 0);
      repeat (3) @(negedge clk);
      reset = 1;
      start_scan(9, 100, 3, 21);
      repeat (8) @(negedge clk);
      i_start = 1;
      @(negedge clk);
      i_start = 0;
      wait_done();
      repeat (20) @(negedge clk);
      check("single_done", done_cnt - d0, 1);
      check("sb_empty", sb.size(), 0);
      fill(0); mem[0] = 1; mem[1] = 2; mem[2] = 3;
      i_threshold = 2;
      run(3, 2, 3, 6);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
